// File: rtl/ddrphy_dqs_delay_tracker.sv
// DQS/DQ IOD delay-line controller: absolute tap moves/loads from a command port,
// plus round-robin eye-monitor tracking that nudges taps one step at a time.
module ddrphy_dqs_delay_tracker #(
  parameter int NUM_LANES    = 4,
  parameter int LANE_W       = 2,
  parameter int TAP_W        = 8,
  parameter int MOVE_GAP     = 4,
  parameter int TRACK_THRESH = 4
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [LANE_W-1:0]            CMD_LANE,
  input  logic [1:0]                   CMD_OP,
  input  logic [TAP_W-1:0]             CMD_TAP,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY,
  input  logic [NUM_LANES-1:0]         EYE_MONITOR_LATE,
  output logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS,
  output logic [NUM_LANES*TAP_W-1:0]   TAP_COUNT,
  output logic [NUM_LANES-1:0]         TRACK_EN,
  output logic [NUM_LANES-1:0]         OOR_ERR
);

  localparam int CNT_W = 4;
  localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MOVE_GAP - 1);
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(TRACK_THRESH);
  localparam logic [TAP_W-1:0]  TAP_MAX   = '1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_MOVE_TO   = 2'b01;
  localparam logic [1:0] OP_TRACK_ON  = 2'b10;
  localparam logic [1:0] OP_TRACK_OFF = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_GAP} state_t;

  state_t               state;
  logic                 cmd_move;
  logic [LANE_W-1:0]    lane_q;
  logic [TAP_W-1:0]     target_q;
  logic                 up_q;
  logic [GAP_W-1:0]     gap_cnt;
  logic [LANE_W-1:0]    ptr;
  logic [NUM_LANES-1:0] move_q;
  logic [NUM_LANES-1:0] dir_q;
  logic [NUM_LANES-1:0] load_q;
  logic [NUM_LANES-1:0] clear_q;
  logic [NUM_LANES-1:0] track_q;
  logic [NUM_LANES-1:0] oor_q;
  logic [TAP_W-1:0]     tap_q   [NUM_LANES];
  logic [CNT_W-1:0]     early_q [NUM_LANES];
  logic [CNT_W-1:0]     late_q  [NUM_LANES];

  logic                 accept;
  logic                 lane_ok;
  logic [TAP_W-1:0]     cmd_cur;
  logic                 cmd_up;
  logic                 pend;
  logic [LANE_W-1:0]    pend_lane;
  logic                 pend_up;
  logic                 pend_blocked;
  logic [LANE_W-1:0]    ptr_next;
  logic                 samp_early;
  logic                 samp_late;

  function automatic logic [TAP_W-1:0] step_tap(input logic [TAP_W-1:0] tap, input logic up);
    return up ? tap + 1'b1 : tap - 1'b1;
  endfunction

  assign CMD_READY = (state == S_IDLE);
  assign accept    = CMD_VALID && (state == S_IDLE);
  assign lane_ok   = int'(CMD_LANE) < NUM_LANES;
  assign cmd_cur   = tap_q[CMD_LANE];
  assign cmd_up    = CMD_TAP > cmd_cur;
  assign ptr_next  = (ptr == LANE_LAST) ? '0 : ptr + 1'b1;
  assign samp_early = EYE_MONITOR_EARLY[ptr];
  assign samp_late  = EYE_MONITOR_LATE[ptr];

  // Lowest-numbered lane with a saturated counter wins the next tracking slot.
  always_comb begin
    pend      = 1'b0;
    pend_lane = '0;
    pend_up   = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (early_q[i] >= THRESH || late_q[i] >= THRESH) begin
        pend      = 1'b1;
        pend_lane = LANE_W'(i);
        pend_up   = early_q[i] >= THRESH;
      end
    end
  end

  assign pend_blocked = pend_up ? (tap_q[pend_lane] == TAP_MAX) : (tap_q[pend_lane] == '0);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state    <= S_IDLE;
      cmd_move <= 1'b0;
      lane_q   <= '0;
      target_q <= '0;
      up_q     <= 1'b0;
      gap_cnt  <= '0;
      ptr      <= '0;
      move_q   <= '0;
      dir_q    <= '0;
      load_q   <= '0;
      clear_q  <= '0;
      track_q  <= '0;
      oor_q    <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        tap_q[i]   <= '0;
        early_q[i] <= '0;
        late_q[i]  <= '0;
      end
    end else begin
      move_q  <= '0;
      load_q  <= '0;
      clear_q <= '0;
      ptr     <= ptr_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (lane_ok) begin
              case (CMD_OP)
                OP_LOAD: begin
                  state            <= S_LOAD;
                  cmd_move         <= 1'b0;
                  lane_q           <= CMD_LANE;
                  load_q[CMD_LANE] <= 1'b1;
                end
                OP_MOVE_TO: begin
                  if (CMD_TAP != cmd_cur) begin
                    state            <= S_STEP;
                    cmd_move         <= 1'b1;
                    lane_q           <= CMD_LANE;
                    target_q         <= CMD_TAP;
                    up_q             <= cmd_up;
                    move_q[CMD_LANE] <= 1'b1;
                    dir_q[CMD_LANE]  <= cmd_up;
                  end
                end
                OP_TRACK_ON: begin
                  track_q[CMD_LANE] <= 1'b1;
                  early_q[CMD_LANE] <= '0;
                  late_q[CMD_LANE]  <= '0;
                end
                OP_TRACK_OFF: begin
                  track_q[CMD_LANE] <= 1'b0;
                  early_q[CMD_LANE] <= '0;
                  late_q[CMD_LANE]  <= '0;
                end
              endcase
            end
          end else if (pend) begin
            // A step off either end of the line is refused and flagged instead.
            early_q[pend_lane] <= '0;
            late_q[pend_lane]  <= '0;
            clear_q[pend_lane] <= 1'b1;
            if (pend_blocked) begin
              oor_q[pend_lane] <= 1'b1;
            end else begin
              state             <= S_STEP;
              cmd_move          <= 1'b0;
              lane_q            <= pend_lane;
              up_q              <= pend_up;
              move_q[pend_lane] <= 1'b1;
              dir_q[pend_lane]  <= pend_up;
            end
          end else if (track_q[ptr]) begin
            if (samp_early && !samp_late) begin
              early_q[ptr] <= early_q[ptr] + 1'b1;
              late_q[ptr]  <= '0;
            end else if (samp_late && !samp_early) begin
              late_q[ptr]  <= late_q[ptr] + 1'b1;
              early_q[ptr] <= '0;
            end
          end
        end
        S_LOAD: begin
          tap_q[lane_q]   <= '0;
          oor_q[lane_q]   <= 1'b0;
          early_q[lane_q] <= '0;
          late_q[lane_q]  <= '0;
          gap_cnt         <= '0;
          state           <= S_GAP;
        end
        S_STEP: begin
          tap_q[lane_q] <= step_tap(tap_q[lane_q], up_q);
          gap_cnt       <= '0;
          state         <= S_GAP;
        end
        S_GAP: begin
          if (cmd_move && DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            oor_q[lane_q] <= 1'b1;
            state         <= S_IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            if (cmd_move && tap_q[lane_q] != target_q) begin
              state          <= S_STEP;
              move_q[lane_q] <= 1'b1;
              dir_q[lane_q]  <= up_q;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign DELAY_LINE_MOVE         = move_q;
  assign DELAY_LINE_DIRECTION    = dir_q;
  assign DELAY_LINE_LOAD         = load_q;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_q;
  assign TRACK_EN                = track_q;
  assign OOR_ERR                 = oor_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
    assign TAP_COUNT[g*TAP_W +: TAP_W] = tap_q[g];
  end

endmodule

// File: tb/tb_ddrphy_dqs_delay_tracker.sv
// Directed bench for ddrphy_dqs_delay_tracker: expected pulse events are queued when a
// command is issued and matched against pulses observed on the outputs.
module tb_ddrphy_dqs_delay_tracker;
  localparam int NL  = 4;
  localparam int LW  = 2;
  localparam int TW  = 8;
  localparam int GAP = 4;
  localparam int THR = 4;

  localparam logic [1:0] OP_LOAD = 2'b00, OP_MOVE = 2'b01, OP_TON = 2'b10, OP_TOFF = 2'b11;

  logic              fab_clk;
  logic              arst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LW-1:0]     cmd_lane;
  logic [1:0]        cmd_op;
  logic [TW-1:0]     cmd_tap;
  logic [NL-1:0]     dl_move, dl_dir, dl_load, dl_oor, em_early, em_late, em_clear;
  logic [NL*TW-1:0]  tap_count;
  logic [NL-1:0]     track_en, oor_err;

  ddrphy_dqs_delay_tracker #(
    .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW), .MOVE_GAP(GAP), .TRACK_THRESH(THR)
  ) dut (
    .FAB_CLK(fab_clk), .ARST_N(arst_n),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_LANE(cmd_lane),
    .CMD_OP(cmd_op), .CMD_TAP(cmd_tap),
    .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor), .EYE_MONITOR_EARLY(em_early), .EYE_MONITOR_LATE(em_late),
    .EYE_MONITOR_CLEAR_FLAGS(em_clear), .TAP_COUNT(tap_count), .TRACK_EN(track_en),
    .OOR_ERR(oor_err)
  );

  typedef struct packed {
    int            cyc;
    logic [NL-1:0] move;
    logic [NL-1:0] load;
    logic [NL-1:0] clr;
    logic [NL-1:0] dir;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           obs_q[$];
  int            cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  int            t0;
  int            c_rst;
  int            s4;
  logic [TW-1:0] tap_m [NL];
  logic [NL-1:0] dir_m;

  initial fab_clk = 1'b0;
  always #5 fab_clk = ~fab_clk;
  always @(posedge fab_clk) cyc <= cyc + 1;

  always @(negedge fab_clk) begin
    if (|{dl_move, dl_load, em_clear}) begin
      ev_t o;
      o.cyc  = cyc;
      o.move = dl_move;
      o.load = dl_load;
      o.clr  = em_clear;
      o.dir  = dl_dir;
      obs_q.push_back(o);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NL*TW-1:0] taps_exp();
    logic [NL*TW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*TW +: TW] = tap_m[i];
    return r;
  endfunction

  task automatic push_ev(input int c, input logic [NL-1:0] mv, input logic [NL-1:0] ld,
                         input logic [NL-1:0] cl);
    ev_t e;
    e.cyc  = c;
    e.move = mv;
    e.load = ld;
    e.clr  = cl;
    e.dir  = dir_m;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else begin
        o = '0;
        o.cyc = -1;
      end
      check({tag, "_ev_cyc"}, o.cyc, e.cyc);
      check({tag, "_ev_move"}, o.move, e.move);
      check({tag, "_ev_load"}, o.load, e.load);
      check({tag, "_ev_clear"}, o.clr, e.clr);
      check({tag, "_ev_dir"}, o.dir, e.dir);
    end
    check({tag, "_extra_events"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic send(input logic [1:0] op, input int lane, input logic [TW-1:0] tap);
    @(negedge fab_clk);
    check("cmd_ready_before_send", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_lane  = LW'(lane);
    cmd_tap   = tap;
    t0        = cyc;
    @(posedge fab_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_tap   = 8'hA5;
  endtask

  task automatic wait_ready(input int exp_cyc, input string tag);
    int n = 0;
    @(negedge fab_clk);
    while (!cmd_ready && n < 400) begin
      @(negedge fab_clk);
      n++;
    end
    check(tag, cmd_ready ? cyc : -1, exp_cyc);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    do begin
      @(negedge fab_clk);
      n++;
    end while (cyc < target && n < 500);
  endtask

  initial begin
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_lane = '0; cmd_op = '0; cmd_tap = '0;
    dl_oor = '0; em_early = '0; em_late = '0;
    for (int i = 0; i < NL; i++) tap_m[i] = '0;
    dir_m = '0;
    repeat (3) @(negedge fab_clk);
    arst_n = 1'b1;
    c_rst  = cyc;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_move", dl_move, '0);
    check("rst_load", dl_load, '0);
    check("rst_clear", em_clear, '0);
    check("rst_dir", dl_dir, '0);
    check("rst_tap", tap_count, '0);
    check("rst_track", track_en, '0);
    check("rst_oor", oor_err, '0);

    // LOAD lane 2
    send(OP_LOAD, 2, 8'd0);
    push_ev(t0 + 1, 4'b0000, 4'b0100, 4'b0000);
    wait_ready(t0 + GAP + 2, "load2_ready");
    check("load2_tap", tap_count, taps_exp());
    compare_events("load2");

    // MOVE_TO lane 1 tap 3, CMD_TAP scrambled after accept
    send(OP_MOVE, 1, 8'd3);
    dir_m[1] = 1'b1;
    for (int k = 0; k < 3; k++) push_ev(t0 + 1 + k*(GAP+1), 4'b0010, 4'b0000, 4'b0000);
    wait_ready(t0 + 3*(GAP+1) + 1, "move_up_ready");
    tap_m[1] = 8'd3;
    check("move_up_tap", tap_count, taps_exp());
    check("move_up_dir_held", dl_dir, dir_m);
    compare_events("move_up");

    // MOVE_TO lane 1 tap 1 (down)
    send(OP_MOVE, 1, 8'd1);
    dir_m[1] = 1'b0;
    for (int k = 0; k < 2; k++) push_ev(t0 + 1 + k*(GAP+1), 4'b0010, 4'b0000, 4'b0000);
    wait_ready(t0 + 2*(GAP+1) + 1, "move_dn_ready");
    tap_m[1] = 8'd1;
    check("move_dn_tap", tap_count, taps_exp());
    compare_events("move_dn");

    // MOVE_TO current tap: no pulse, ready at cycle 1
    send(OP_MOVE, 1, 8'd1);
    wait_ready(t0 + 1, "move_d0_ready");
    check("move_d0_tap", tap_count, taps_exp());
    compare_events("move_d0");

    // Tracking lane 0 with EARLY held: one increment step
    em_early[0] = 1'b1;
    send(OP_TON, 0, 8'd0);
    check("trk0_en", track_en, 4'b0001);
    s4 = t0 + 1;
    while ((s4 - c_rst) % NL != 0) s4++;
    s4 = s4 + (THR - 1) * NL;
    dir_m[0] = 1'b1;
    push_ev(s4 + 2, 4'b0001, 4'b0000, 4'b0001);
    wait_cyc(s4 + 3);
    em_early[0] = 1'b0;
    wait_ready(s4 + 2 + GAP + 1, "trk0_ready");
    tap_m[0] = 8'd1;
    check("trk0_tap", tap_count, taps_exp());
    compare_events("trk0");
    send(OP_TOFF, 0, 8'd0);
    check("trk0_off", track_en, 4'b0000);
    wait_ready(t0 + 1, "trk0_off_ready");

    // Tracking lane 3 at tap 0 with LATE held: refused step
    em_late[3] = 1'b1;
    send(OP_TON, 3, 8'd0);
    check("trk3_en", track_en, 4'b1000);
    s4 = t0 + 1;
    while ((s4 - c_rst) % NL != 3) s4++;
    s4 = s4 + (THR - 1) * NL;
    push_ev(s4 + 2, 4'b0000, 4'b0000, 4'b1000);
    wait_cyc(s4 + 2);
    check("trk3_oor", oor_err, 4'b1000);
    check("trk3_ready", cmd_ready, 1'b1);
    em_late[3] = 1'b0;
    send(OP_TOFF, 3, 8'd0);
    wait_ready(t0 + 1, "trk3_off_ready");
    send(OP_LOAD, 3, 8'd0);
    push_ev(t0 + 1, 4'b0000, 4'b1000, 4'b0000);
    wait_ready(t0 + GAP + 2, "load3_ready");
    check("load3_oor_clr", oor_err, 4'b0000);
    check("load3_tap", tap_count, taps_exp());
    compare_events("trk3");

    // Out-of-range abort during MOVE_TO lane 0 tap 10
    send(OP_LOAD, 0, 8'd0);
    push_ev(t0 + 1, 4'b0000, 4'b0001, 4'b0000);
    wait_ready(t0 + GAP + 2, "load0_ready");
    tap_m[0] = 8'd0;
    send(OP_MOVE, 0, 8'd10);
    for (int k = 0; k < 2; k++) push_ev(t0 + 1 + k*(GAP+1), 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(t0 + 2*(GAP+1));
    dl_oor[0] = 1'b1;
    wait_ready(t0 + 2*(GAP+1) + 1, "oor_abort_ready");
    dl_oor[0] = 1'b0;
    tap_m[0] = 8'd2;
    check("oor_abort_err", oor_err, 4'b0001);
    check("oor_abort_tap", tap_count, taps_exp());
    compare_events("oor_abort");

    // Reset mid-move on lane 1 (tap 1 -> 9)
    send(OP_MOVE, 1, 8'd9);
    dir_m[1] = 1'b1;
    for (int k = 0; k < 2; k++) push_ev(t0 + 1 + k*(GAP+1), 4'b0010, 4'b0000, 4'b0000);
    wait_cyc(t0 + 1 + (GAP+1));
    check("pre_rst_move", dl_move, 4'b0010);
    #1 arst_n = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) tap_m[i] = '0;
    dir_m = '0;
    check("mid_rst_move", dl_move, '0);
    check("mid_rst_dir", dl_dir, '0);
    check("mid_rst_tap", tap_count, taps_exp());
    check("mid_rst_oor", oor_err, '0);
    check("mid_rst_track", track_en, '0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    @(negedge fab_clk);
    arst_n = 1'b1;
    repeat (3*(GAP+1)) @(negedge fab_clk);
    check("post_rst_tap", tap_count, taps_exp());
    check("post_rst_ready", cmd_ready, 1'b1);
    compare_events("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddrphy_dqs_delay_tracker.md
Name: ddrphy_dqs_delay_tracker

Overview:
- Multi-lane delay-line controller for the DDR PHY DQS/DQ IOD lanes.
- Owns the DELAY_LINE_MOVE/DIRECTION/LOAD and EYE_MONITOR_CLEAR_FLAGS controls of NUM_LANES IOD instances, and keeps a shadow tap count per lane.
- Runs absolute tap moves and loads from a valid/ready command port (training logic).
- Runs background per-lane eye-monitor tracking that nudges taps in response to EARLY/LATE flags.

Parameters:
- NUM_LANES, 4, number of IOD lanes controlled.
- LANE_W, 2, command lane index width; 2^LANE_W >= NUM_LANES.
- TAP_W, 8, tap counter width; legal taps 0..2^TAP_W-1.
- MOVE_GAP, 4, idle cycles after every MOVE/LOAD pulse; minimum 1.
- TRACK_THRESH, 4, consecutive-qualified samples needed before a tracking move; range 1..15.

Ports:
- FAB_CLK  in  1  sole clock.
- ARST_N  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accept; CMD_VALID&CMD_READY = accepted.
- CMD_LANE  in  LANE_W  target lane; values >= NUM_LANES are ignored (accepted, no effect).
- CMD_OP  in  2  00 LOAD, 01 MOVE_TO, 10 TRACK_ON, 11 TRACK_OFF.
- CMD_TAP  in  TAP_W  absolute target tap for MOVE_TO.
- DELAY_LINE_MOVE  out  NUM_LANES  one-cycle move pulses.
- DELAY_LINE_DIRECTION  out  NUM_LANES  1 = increment; registered, held until that lane's next move.
- DELAY_LINE_LOAD  out  NUM_LANES  one-cycle load pulse; resets the IOD delay to tap 0.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  IOD range flag.
- EYE_MONITOR_EARLY  in  NUM_LANES  IOD early flag.
- EYE_MONITOR_LATE  in  NUM_LANES  IOD late flag.
- EYE_MONITOR_CLEAR_FLAGS  out  NUM_LANES  one-cycle clear pulse.
- TAP_COUNT  out  NUM_LANES*TAP_W  shadow taps; lane i at [i*TAP_W +: TAP_W].
- TRACK_EN  out  NUM_LANES  tracking enabled per lane.
- OOR_ERR  out  NUM_LANES  sticky range error; cleared by LOAD of that lane.

Behaviour:
- Reset values: all pulse outputs, DIRECTION, TAP_COUNT, TRACK_EN and OOR_ERR are 0; internal early/late counters are 0; the FSM is in IDLE, so CMD_READY=1.
  - Reset asserted mid-operation aborts immediately; no further pulse is issued.
- FSM states: IDLE, LOAD, STEP, GAP.
  - CMD_READY=1 only in IDLE (combinational from state).
  - The accept cycle is cycle 0.
- LOAD:
  - Cycle 1: LOAD[lane]=1; TAP_COUNT[lane]<=0; OOR_ERR[lane]<=0; that lane's counters are cleared.
  - Then GAP for MOVE_GAP cycles; IDLE at cycle MOVE_GAP+2.
- MOVE_TO with d = |CMD_TAP - TAP_COUNT[lane]|:
  - d=0: return to IDLE at cycle 1; no pulse.
  - Otherwise STEP: MOVE[lane]=1 and DIRECTION[lane]=(CMD_TAP>tap) in the same cycle; tap +/-1 registered in that cycle.
  - Then GAP for MOVE_GAP cycles, and repeat until the tap equals the target.
  - Pulses occur at cycles 1 + k*(MOVE_GAP+1), k = 0..d-1; CMD_READY returns at cycle d*(MOVE_GAP+1)+1.
  - The target is latched at accept; later changes to CMD_TAP have no effect.
  - If DELAY_LINE_OUT_OF_RANGE[lane] is sampled high in any GAP cycle: set OOR_ERR[lane], abort to IDLE next cycle, keep TAP_COUNT as counted.
- TRACK_ON / TRACK_OFF:
  - TRACK_EN[lane] set/cleared at cycle 1; the lane's counters are cleared; IDLE at cycle 1.
- Tracking (IDLE only, when no command is accepted in that cycle):
  - A round-robin pointer advances every cycle modulo NUM_LANES and advances regardless of TRACK_EN.
  - The lane at the pointer is sampled only if TRACK_EN=1:
    - EARLY&!LATE: early_cnt+1, late_cnt cleared.
    - LATE&!EARLY: late_cnt+1, early_cnt cleared.
    - Both or neither: no change.
  - When a count reaches TRACK_THRESH, in the next cycle:
    - Enter STEP with DIRECTION=1 if early, 0 if late.
    - Pulse CLEAR_FLAGS[lane] in the same cycle as MOVE.
    - Clear both counters, then GAP, then IDLE.
  - A tracking step that would move below 0 or above 2^TAP_W-1 issues no MOVE, sets OOR_ERR[lane] and pulses CLEAR_FLAGS only.
- Simultaneous events: a command accepted in IDLE has priority over a pending tracking move. The pending move is discarded and its counters are kept.
- TAP_COUNT never wraps; MOVE_TO targets are always in range by construction.

Test Plan:
- Reset, then LOAD lane 2 -> LOAD[2] pulses at cycle 1; TAP_COUNT lane 2 = 0; CMD_READY returns at cycle 6 (MOVE_GAP=4).
- MOVE_TO lane 1, tap 3 from 0 -> MOVE[1] pulses at cycles 1, 6, 11 with DIRECTION[1]=1; TAP_COUNT=3; CMD_READY at cycle 16.
- MOVE_TO lane 1, tap 1 from 3 -> two pulses with DIRECTION[1]=0; TAP_COUNT=1. Then MOVE_TO lane 1, tap 1 -> CMD_READY at cycle 1 with no pulse.
- TRACK_ON lane 0 with EARLY[0] held high, TRACK_THRESH=4 -> after 4 samples of lane 0 (every 4th cycle), one MOVE[0] with DIRECTION=1 plus CLEAR_FLAGS[0]; TAP_COUNT increments by 1.
- Lane 3 at tap 0, tracking, LATE[3] held high -> no MOVE; OOR_ERR[3]=1 and CLEAR_FLAGS[3] pulses. A following LOAD of lane 3 clears OOR_ERR[3].
- MOVE_TO lane 0, tap 10 with OUT_OF_RANGE[0] raised after the 2nd pulse -> abort; OOR_ERR[0]=1; TAP_COUNT=2; CMD_READY high the next cycle. Asserting ARST_N low mid-move zeroes all outputs at once.
